// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the hazard event
// priority list and the counter-width default.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    // Listed highest priority first; EV_NONE means default controls.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_RESET    = 3'd1,
        EV_DMEM     = 3'd2,
        EV_MULDIV   = 3'd3,
        EV_BRANCH   = 3'd4,
        EV_LOAD_USE = 3'd5,
        EV_IMEM     = 3'd6
    } hazard_ev_t;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush controls back to its registers.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_RS1_ADDR;
    logic [4:0]       ID_RS2_ADDR;
    logic             ID_RS1_USED;
    logic             ID_RS2_USED;
    logic [4:0]       EX_RD_ADDR;
    logic             EX_MEM_READ;
    logic             EX_BRANCH_TAKEN;
    logic             EX_MULDIV_START;
    logic             IMEM_BUSYWAIT;
    logic             DMEM_BUSYWAIT;

    logic             PC_EN;
    logic             IF_ID_EN;
    logic             IF_ID_FLUSH;
    logic             ID_EX_EN;
    logic             ID_EX_FLUSH;
    logic             EX_MEM_EN;
    logic             EX_MEM_FLUSH;
    logic             MEM_WB_FLUSH;
    logic [CNT_W-1:0] STALL_CYCLES;
    logic [CNT_W-1:0] FLUSH_COUNT;
    logic             ERROR;

    modport master (
        output ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED, EX_RD_ADDR,
               EX_MEM_READ, EX_BRANCH_TAKEN, EX_MULDIV_START, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        input  PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN,
               EX_MEM_FLUSH, MEM_WB_FLUSH, STALL_CYCLES, FLUSH_COUNT, ERROR
    );

    modport slave (
        input  ID_RS1_ADDR, ID_RS2_ADDR, ID_RS1_USED, ID_RS2_USED, EX_RD_ADDR,
               EX_MEM_READ, EX_BRANCH_TAKEN, EX_MULDIV_START, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        output PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN,
               EX_MEM_FLUSH, MEM_WB_FLUSH, STALL_CYCLES, FLUSH_COUNT, ERROR
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// x0 never creates a dependency since it is hard-wired to zero.
module load_use_detector (
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rd_addr,
    input  logic       mem_read,
    output logic       hazard
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_used && (rs1_addr == rd_addr);
    assign rs2_hit = rs2_used && (rs2_addr == rd_addr);
    assign hazard  = mem_read && (rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritised hazard resolution,
// MUL/DIV occupancy FSM, saturating performance counters and a sticky DMEM timeout.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int BUSY_TIMEOUT   = 255,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    pipeline_hazard_ctrl_if.slave bus,
    output md_state_t             state_dbg,
    output hazard_ev_t            event_dbg
);
    localparam int MD_W   = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY - 1) : 1;
    localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [MD_W-1:0]   MD_INIT  = MD_W'((MULDIV_LATENCY > 1) ? MULDIV_LATENCY - 2 : 0);
    localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(BUSY_TIMEOUT);

    md_state_t          state, state_next;
    logic [MD_W-1:0]    md_cnt, md_cnt_next;
    logic [BUSY_W-1:0]  busy_cnt, busy_cnt_inc;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    logic               error_q;
    hazard_ev_t         ev;
    logic               load_use;
    logic               md_start;
    logic               md_stall;

    load_use_detector u_load_use (
        .rs1_addr (bus.ID_RS1_ADDR),
        .rs2_addr (bus.ID_RS2_ADDR),
        .rs1_used (bus.ID_RS1_USED),
        .rs2_used (bus.ID_RS2_USED),
        .rd_addr  (bus.EX_RD_ADDR),
        .mem_read (bus.EX_MEM_READ),
        .hazard   (load_use)
    );

    // A MUL/DIV entering EX stalls in its first cycle; the release cycle ignores START.
    assign md_start = (state == RUN) && bus.EX_MULDIV_START && (MULDIV_LATENCY > 1);
    assign md_stall = md_start || ((state == MD_WAIT) && (md_cnt != '0));

    always_comb begin
        bus.PC_EN        = 1'b1;
        bus.IF_ID_EN     = 1'b1;
        bus.IF_ID_FLUSH  = 1'b0;
        bus.ID_EX_EN     = 1'b1;
        bus.ID_EX_FLUSH  = 1'b0;
        bus.EX_MEM_EN    = 1'b1;
        bus.EX_MEM_FLUSH = 1'b0;
        bus.MEM_WB_FLUSH = 1'b0;
        state_next       = state;
        md_cnt_next      = md_cnt;
        ev               = EV_NONE;

        if (RESET) begin
            ev               = EV_RESET;
            bus.PC_EN        = 1'b0;
            bus.IF_ID_EN     = 1'b0;
            bus.IF_ID_FLUSH  = 1'b1;
            bus.ID_EX_EN     = 1'b0;
            bus.ID_EX_FLUSH  = 1'b1;
            bus.EX_MEM_EN    = 1'b0;
            bus.EX_MEM_FLUSH = 1'b1;
            bus.MEM_WB_FLUSH = 1'b1;
        end else if (bus.DMEM_BUSYWAIT) begin
            // Everything upstream of MEM freezes, including the FSM and md_cnt.
            ev               = EV_DMEM;
            bus.PC_EN        = 1'b0;
            bus.IF_ID_EN     = 1'b0;
            bus.ID_EX_EN     = 1'b0;
            bus.EX_MEM_EN    = 1'b0;
            bus.MEM_WB_FLUSH = 1'b1;
        end else if (md_stall) begin
            ev               = EV_MULDIV;
            bus.PC_EN        = 1'b0;
            bus.IF_ID_EN     = 1'b0;
            bus.ID_EX_EN     = 1'b0;
            bus.EX_MEM_FLUSH = 1'b1;
            if (md_start) begin
                state_next  = MD_WAIT;
                md_cnt_next = MD_INIT;
            end else begin
                md_cnt_next = md_cnt - 1'b1;
            end
        end else begin
            if (state == MD_WAIT) begin
                state_next = RUN;
            end
            if (bus.EX_BRANCH_TAKEN) begin
                ev              = EV_BRANCH;
                bus.IF_ID_FLUSH = 1'b1;
                bus.ID_EX_FLUSH = 1'b1;
            end else if (load_use) begin
                ev              = EV_LOAD_USE;
                bus.PC_EN       = 1'b0;
                bus.IF_ID_EN    = 1'b0;
                bus.ID_EX_FLUSH = 1'b1;
            end else if (bus.IMEM_BUSYWAIT) begin
                ev              = EV_IMEM;
                bus.PC_EN       = 1'b0;
                bus.IF_ID_FLUSH = 1'b1;
            end
        end
    end

    assign busy_cnt_inc = (busy_cnt == BUSY_MAX) ? busy_cnt : busy_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= RUN;
            md_cnt    <= '0;
            busy_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            error_q   <= 1'b0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
            if (bus.DMEM_BUSYWAIT) begin
                busy_cnt <= busy_cnt_inc;
                if (busy_cnt_inc == BUSY_MAX) begin
                    error_q <= 1'b1;
                end
            end else begin
                busy_cnt <= '0;
            end
            if (!bus.PC_EN && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((ev == EV_BRANCH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.STALL_CYCLES = stall_cnt;
    assign bus.FLUSH_COUNT  = flush_cnt;
    assign bus.ERROR        = error_q;
    assign state_dbg        = state;
    assign event_dbg        = ev;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hand-computed control words and counter
// values for each hazard scenario, checked with immediate assertions.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int CW = 8;

    // Control word order: PC_EN IF_ID_EN IF_ID_FLUSH ID_EX_EN ID_EX_FLUSH EX_MEM_EN EX_MEM_FLUSH MEM_WB_FLUSH
    localparam logic [7:0] C_DEFAULT = 8'b1101_0100;
    localparam logic [7:0] C_RESET   = 8'b0010_1011;
    localparam logic [7:0] C_DMEM    = 8'b0000_0001;
    localparam logic [7:0] C_MD      = 8'b0000_0110;
    localparam logic [7:0] C_BRANCH  = 8'b1111_1100;
    localparam logic [7:0] C_LOADUSE = 8'b0001_1100;
    localparam logic [7:0] C_IMEM    = 8'b0111_0100;

    logic       CLK;
    logic       RESET;
    md_state_t  state_dbg;
    hazard_ev_t event_dbg;
    logic [7:0] ctrl;
    int         checks;
    int         errors;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .MULDIV_LATENCY (4),
        .BUSY_TIMEOUT   (255),
        .CNT_W          (CW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .state_dbg (state_dbg),
        .event_dbg (event_dbg)
    );

    assign ctrl = {bus.PC_EN, bus.IF_ID_EN, bus.IF_ID_FLUSH, bus.ID_EX_EN,
                   bus.ID_EX_FLUSH, bus.EX_MEM_EN, bus.EX_MEM_FLUSH, bus.MEM_WB_FLUSH};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ID_RS1_ADDR     = 5'd0;
        bus.ID_RS2_ADDR     = 5'd0;
        bus.ID_RS1_USED     = 1'b0;
        bus.ID_RS2_USED     = 1'b0;
        bus.EX_RD_ADDR      = 5'd0;
        bus.EX_MEM_READ     = 1'b0;
        bus.EX_BRANCH_TAKEN = 1'b0;
        bus.EX_MULDIV_START = 1'b0;
        bus.IMEM_BUSYWAIT   = 1'b0;
        bus.DMEM_BUSYWAIT   = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
        bus.EX_MEM_READ = 1'b1;
        bus.EX_RD_ADDR  = rd;
        bus.ID_RS1_ADDR = rs1;
        bus.ID_RS1_USED = u1;
        bus.ID_RS2_ADDR = rs2;
        bus.ID_RS2_USED = u2;
    endtask

    // Checks the combinational controls mid-cycle, then advances one clock.
    task automatic step(input string tag, input logic [7:0] exp_ctrl);
        @(negedge CLK);
        check(tag, 32'(ctrl), 32'(exp_ctrl));
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int stall, input int flush);
        check({tag, "_stall"}, 32'(bus.STALL_CYCLES), 32'(stall));
        check({tag, "_flush"}, 32'(bus.FLUSH_COUNT), 32'(flush));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        RESET = 1'b1;
        step("reset_ctrl", C_RESET);
        step("reset_ctrl2", C_RESET);
        RESET = 1'b0;
        check_cnt("post_reset", 0, 0);
        check("post_reset_err", 32'(bus.ERROR), 32'd0);
        check("post_reset_state", 32'(state_dbg), 32'(RUN));
        step("idle", C_DEFAULT);

        load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_rs1", C_LOADUSE);
        idle();
        step("lu_after", C_DEFAULT);
        check_cnt("lu_rs1", 1, 0);

        load(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_x0", C_DEFAULT);
        load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        step("lu_rs2", C_LOADUSE);
        load(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        step("lu_rs2_unused", C_DEFAULT);
        idle();
        check_cnt("lu_rs2", 2, 0);

        load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        bus.IMEM_BUSYWAIT   = 1'b1;
        bus.EX_BRANCH_TAKEN = 1'b1;
        step("branch_override", C_BRANCH);
        idle();
        check_cnt("branch", 2, 1);

        bus.IMEM_BUSYWAIT = 1'b1;
        step("imem", C_IMEM);
        idle();
        check_cnt("imem", 3, 1);

        // MUL with latency 4: three stall cycles then a normal release cycle.
        bus.EX_MULDIV_START = 1'b1;
        step("mul_c0", C_MD);
        check("mul_state", 32'(state_dbg), 32'(MD_WAIT));
        step("mul_c1", C_MD);
        step("mul_c2", C_MD);
        step("mul_release", C_DEFAULT);
        check("mul_state_run", 32'(state_dbg), 32'(RUN));
        bus.EX_MULDIV_START = 1'b0;
        check_cnt("mul", 6, 1);

        // MUL with two DMEM busy cycles injected: six cycles of EX occupancy.
        bus.EX_MULDIV_START = 1'b1;
        step("muld_c0", C_MD);
        step("muld_c1", C_MD);
        bus.DMEM_BUSYWAIT = 1'b1;
        step("muld_dmem0", C_DMEM);
        step("muld_dmem1", C_DMEM);
        check("muld_frozen_state", 32'(state_dbg), 32'(MD_WAIT));
        bus.DMEM_BUSYWAIT = 1'b0;
        step("muld_c2", C_MD);
        step("muld_release", C_DEFAULT);
        idle();
        check_cnt("muld", 11, 1);

        // A branch arriving under a DMEM stall is held, then taken on release.
        bus.EX_BRANCH_TAKEN = 1'b1;
        bus.DMEM_BUSYWAIT   = 1'b1;
        step("branch_held", C_DMEM);
        check_cnt("branch_held", 12, 1);
        bus.DMEM_BUSYWAIT = 1'b0;
        step("branch_released", C_BRANCH);
        idle();
        check_cnt("branch_released", 12, 2);

        // DMEM timeout: ERROR on the 255th consecutive busy cycle; stall counter saturates.
        bus.DMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 254; i++) begin
            @(posedge CLK);
            #1;
        end
        check("timeout_254", 32'(bus.ERROR), 32'd0);
        step("timeout_ctrl", C_DMEM);
        check("timeout_255", 32'(bus.ERROR), 32'd1);
        check("stall_saturated", 32'(bus.STALL_CYCLES), 32'hFF);
        bus.DMEM_BUSYWAIT = 1'b0;
        step("error_no_effect", C_DEFAULT);
        check("error_sticky", 32'(bus.ERROR), 32'd1);
        check("stall_held_sat", 32'(bus.STALL_CYCLES), 32'hFF);

        // RESET in the middle of MD_WAIT aborts the MUL/DIV cleanly.
        bus.EX_MULDIV_START = 1'b1;
        step("mid_md", C_MD);
        RESET = 1'b1;
        step("mid_md_reset", C_RESET);
        RESET = 1'b0;
        idle();
        check("abort_state", 32'(state_dbg), 32'(RUN));
        check_cnt("abort", 0, 0);
        check("abort_err", 32'(bus.ERROR), 32'd0);
        step("abort_ctrl", C_DEFAULT);
        check_cnt("abort_after", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
